// File: rtl/sr_ctrl_pkg.sv
// Shared types and constants for the SR latch bank controller.
package sr_ctrl_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StPulse,
        StHold,
        StCheck
    } state_t;

    localparam logic OP_SET = 1'b1;
    localparam logic OP_CLR = 1'b0;

    // Cycles from one accepted command to the next possible accept.
    function automatic int unsigned seq_len(input int unsigned pulse_cyc);
        return 4 + pulse_cyc;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; on a tie the requester not granted last wins.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] valid,
    input  logic       accept,
    output logic [1:0] grant
);

    logic last_q;  // index of the most recently accepted requester

    always_comb begin
        grant = 2'b00;
        unique case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_q ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else if (accept) begin
            last_q <= grant[1];
        end
    end

endmodule

// File: rtl/sr_bank_ctrl.sv
// Arbitrates set/clear commands from two requesters and sequences setup/pulse/hold
// writes into a bank of gated SR latches, then verifies each write by readback.
module sr_bank_ctrl
    import sr_ctrl_pkg::*;
#(
    parameter  int unsigned WIDTH     = 8,
    parameter  int unsigned PULSE_CYC = 2,
    localparam int unsigned IW        = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic             req0_op,
    input  logic [IW-1:0]    req0_idx,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic             req1_op,
    input  logic [IW-1:0]    req1_idx,
    output logic [WIDTH-1:0] lat_s,
    output logic [WIDTH-1:0] lat_r,
    output logic             lat_en,
    input  logic [WIDTH-1:0] lat_q,
    output logic             busy,
    output logic             err,
    output logic [IW-1:0]    err_idx,
    input  logic             err_clr
);

    localparam int unsigned CW = $clog2(PULSE_CYC + 1);

    state_t            state_q;
    logic [CW-1:0]     cnt_q;
    logic              op_q;
    logic [IW-1:0]     idx_q;
    logic [WIDTH-1:0]  sel_q;

    logic [1:0]        grant;
    logic              idle;
    logic              accept;
    logic              new_op;
    logic [IW-1:0]     new_idx;
    logic [WIDTH-1:0]  new_sel;
    logic              chk_fail;

    rr_arb2 u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .valid  ({req1_valid, req0_valid}),
        .accept (accept),
        .grant  (grant)
    );

    assign idle       = (state_q == StIdle);
    assign busy       = !idle;
    assign req0_ready = idle & grant[0];
    assign req1_ready = idle & grant[1];
    assign accept     = idle & (|grant);
    assign new_op     = grant[1] ? req1_op : req0_op;
    assign new_idx    = grant[1] ? req1_idx : req0_idx;

    // An out-of-range index decodes to an empty select, so nothing is ever driven.
    always_comb begin
        new_sel = '0;
        for (int i = 0; i < WIDTH; i++) begin
            new_sel[i] = (IW'(i) == new_idx);
        end
    end

    assign chk_fail = (state_q == StCheck) &&
                      ((sel_q == '0) || ((|(lat_q & sel_q)) != op_q));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            op_q    <= OP_CLR;
            idx_q   <= '0;
            sel_q   <= '0;
            lat_s   <= '0;
            lat_r   <= '0;
            lat_en  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        state_q <= StSetup;
                        op_q    <= new_op;
                        idx_q   <= new_idx;
                        sel_q   <= new_sel;
                        lat_s   <= (new_op == OP_SET) ? new_sel : '0;
                        lat_r   <= (new_op == OP_SET) ? '0 : new_sel;
                    end
                end
                StSetup: begin
                    state_q <= StPulse;
                    cnt_q   <= '0;
                    lat_en  <= |sel_q;
                end
                StPulse: begin
                    if (cnt_q == CW'(PULSE_CYC - 1)) begin
                        state_q <= StHold;
                        lat_en  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                StHold: begin
                    state_q <= StCheck;
                    lat_s   <= '0;
                    lat_r   <= '0;
                end
                StCheck: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // A new failure takes priority over a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err     <= 1'b0;
            err_idx <= '0;
        end else if (chk_fail) begin
            err     <= 1'b1;
            err_idx <= idx_q;
        end else if (err_clr) begin
            err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sr_bank_ctrl.sv
// Self-checking bench: directed scenarios plus random traffic against a
// schedule-based model of the write sequence and arbitration rules.
module tb_sr_bank_ctrl;

    localparam int unsigned W  = 10;
    localparam int unsigned P  = 2;
    localparam int unsigned IW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req0_valid = 1'b0, req0_op = 1'b0;
    logic [IW-1:0] req0_idx = '0;
    logic          req1_valid = 1'b0, req1_op = 1'b0;
    logic [IW-1:0] req1_idx = '0;
    logic          req0_ready, req1_ready;
    logic [W-1:0]  lat_s, lat_r, lat_q;
    logic          lat_en, busy, err, err_clr = 1'b0;
    logic [IW-1:0] err_idx;

    logic [W-1:0]  bank = '0, stuck1 = '0, stuck0 = '0;
    assign lat_q = (bank | stuck1) & ~stuck0;

    sr_bank_ctrl #(.WIDTH(W), .PULSE_CYC(P)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op    (req0_op),
        .req0_idx   (req0_idx),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op    (req1_op),
        .req1_idx   (req1_idx),
        .lat_s      (lat_s),
        .lat_r      (lat_r),
        .lat_en     (lat_en),
        .lat_q      (lat_q),
        .busy       (busy),
        .err        (err),
        .err_idx    (err_idx),
        .err_clr    (err_clr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: a write is a fixed schedule counted from the accept cycle.
    bit busy_m = 0;
    int p_m = 0;
    bit op_m = 0;
    int idx_m = 0;
    int last_m = 1;
    bit err_m = 0;
    int erridx_m = 0;
    int g_prev = -1;
    int cyc = 0;
    int en_hi = 0;
    int act_cnt = 0;
    int acc_q[$];
    int acc_cyc[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic reset_model();
        busy_m   = 0;
        p_m      = 0;
        last_m   = 1;
        err_m    = 0;
        erridx_m = 0;
        g_prev   = -1;
        acc_q.delete();
        acc_cyc.delete();
    endtask

    task automatic step();
        logic [W-1:0] sel, e_s, e_r;
        bit in_rng, e_en, fail;
        int g;
        @(negedge clk);
        in_rng = (idx_m < int'(W));
        sel = (busy_m && in_rng) ? (W'(1) << idx_m) : '0;
        e_s = '0;
        e_r = '0;
        if (busy_m && p_m >= 1 && p_m <= 2 + P) begin
            e_s = op_m ? sel : '0;
            e_r = op_m ? '0 : sel;
        end
        e_en = busy_m && in_rng && p_m >= 2 && p_m <= 1 + P;
        g = -1;
        if (!busy_m) begin
            if (req0_valid && req1_valid) g = (last_m == 1) ? 0 : 1;
            else if (req0_valid) g = 0;
            else if (req1_valid) g = 1;
        end
        chk("req0_ready", req0_ready, g == 0);
        chk("req1_ready", req1_ready, g == 1);
        chk("busy", busy, busy_m);
        chk("lat_s", lat_s, e_s);
        chk("lat_r", lat_r, e_r);
        chk("lat_en", lat_en, e_en);
        chk("err", err, err_m);
        chk("err_idx", err_idx, erridx_m);
        chk("s_r_overlap", lat_s & lat_r, 0);
        chk("drive_onehot", $countones(lat_s | lat_r) <= 1, 1);

        if (lat_en === 1'b1) en_hi++;
        if ((lat_s | lat_r) != '0 || lat_en !== 1'b0) act_cnt++;
        if (req0_valid && req0_ready) begin acc_q.push_back(0); acc_cyc.push_back(cyc); end
        if (req1_valid && req1_ready) begin acc_q.push_back(1); acc_cyc.push_back(cyc); end

        fail = 0;
        if (busy_m) begin
            if (p_m == 3 + P) begin
                fail   = !in_rng || (lat_q[idx_m] != op_m);
                busy_m = 0;
            end else begin
                p_m++;
            end
        end else if (g >= 0) begin
            busy_m = 1;
            p_m    = 1;
            op_m   = (g == 0) ? req0_op : req1_op;
            idx_m  = (g == 0) ? int'(req0_idx) : int'(req1_idx);
            last_m = g;
        end
        if (fail) begin
            err_m    = 1;
            erridx_m = idx_m;
        end else if (err_clr) begin
            err_m = 0;
        end
        if (lat_en === 1'b1) bank = (bank & ~lat_r) | lat_s;
        g_prev = g;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 20 && busy !== 1'b0; k++) step();
        chk("idle_timeout", busy, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_order[4];
        exp_order = '{0, 1, 0, 1};

        // Reset values
        #3;
        chk("rst_busy", busy, 0);
        chk("rst_lat_s", lat_s, 0);
        chk("rst_lat_r", lat_r, 0);
        chk("rst_lat_en", lat_en, 0);
        chk("rst_err", err, 0);
        chk("rst_err_idx", err_idx, 0);
        chk("rst_ready0", req0_ready, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        reset_model();

        // Tie held for four grants: alternation starting with req0
        req0_valid = 1; req0_op = 1; req0_idx = 4'd0;
        req1_valid = 1; req1_op = 1; req1_idx = 4'd1;
        for (int k = 0; k < 40 && acc_q.size() < 4; k++) step();
        req0_valid = 0; req1_valid = 0;
        chk("tie_count", acc_q.size(), 4);
        if (acc_q.size() == 4) begin
            for (int i = 0; i < 4; i++) chk($sformatf("tie_order%0d", i), acc_q[i], exp_order[i]);
            for (int i = 1; i < 4; i++)
                chk($sformatf("tie_gap%0d", i), acc_cyc[i] - acc_cyc[i-1], 6);
        end
        wait_idle();

        // req0 set idx 3
        en_hi = 0;
        req0_valid = 1; req0_op = 1; req0_idx = 4'd3;
        step();
        req0_valid = 0;
        chk("set_setup_s", lat_s, 10'h008);
        chk("set_setup_r", lat_r, 0);
        chk("set_setup_en", lat_en, 0);
        step(); step(); step();
        chk("set_hold_s", lat_s, 10'h008);
        chk("set_hold_en", lat_en, 0);
        step();
        chk("set_check_s", lat_s, 0);
        chk("set_check_busy", busy, 1);
        step();
        chk("set_done_busy", busy, 0);
        chk("set_en_cycles", en_hi, 2);
        chk("set_err", err, 0);
        chk("set_bank", lat_q[3], 1);
        req0_valid = 1;
        #1;
        chk("set_ready_again", req0_ready, 1);
        req0_valid = 0;
        #1;

        // req1 clear idx 5 with Q stuck high
        stuck1 = 10'h020;
        req1_valid = 1; req1_op = 0; req1_idx = 4'd5;
        step();
        req1_valid = 0;
        wait_idle();
        chk("stuck_err", err, 1);
        chk("stuck_err_idx", err_idx, 5);
        err_clr = 1;
        req1_valid = 1;
        step();
        req1_valid = 0;
        step();
        chk("clr_works", err, 0);
        wait_idle();
        chk("set_beats_clr", err, 1);
        chk("set_beats_clr_idx", err_idx, 5);
        step();
        err_clr = 0;
        chk("clr_idle", err, 0);
        stuck1 = '0;

        // Out-of-range index
        act_cnt = 0;
        req0_valid = 1; req0_op = 1; req0_idx = 4'd12;
        step();
        req0_valid = 0;
        wait_idle();
        chk("oor_activity", act_cnt, 0);
        chk("oor_err", err, 1);
        chk("oor_err_idx", err_idx, 12);
        err_clr = 1;
        step();
        err_clr = 0;

        // Reset during PULSE
        req0_valid = 1; req0_op = 1; req0_idx = 4'd2;
        step();
        req0_valid = 0;
        step();
        chk("mid_pulse_en", lat_en, 1);
        rst_n = 0;
        #1;
        chk("mid_rst_en", lat_en, 0);
        chk("mid_rst_s", lat_s, 0);
        chk("mid_rst_r", lat_r, 0);
        chk("mid_rst_busy", busy, 0);
        reset_model();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
        req0_valid = 1; req0_op = 0; req0_idx = 4'd2;
        req1_valid = 1; req1_op = 0; req1_idx = 4'd4;
        step();
        req0_valid = 0; req1_valid = 0;
        chk("post_rst_first", (acc_q.size() > 0) ? acc_q[0] : 9, 0);
        wait_idle();

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            if (!req0_valid || g_prev == 0) begin
                req0_valid = ($urandom_range(0, 2) == 0);
                req0_op    = 1'($urandom_range(0, 1));
                req0_idx   = 4'($urandom_range(0, 11));
            end
            if (!req1_valid || g_prev == 1) begin
                req1_valid = ($urandom_range(0, 2) == 0);
                req1_op    = 1'($urandom_range(0, 1));
                req1_idx   = 4'($urandom_range(0, 11));
            end
            err_clr = ($urandom_range(0, 9) == 0);
            if (!busy_m && $urandom_range(0, 15) == 0) begin
                stuck1 = '0;
                stuck0 = '0;
                case ($urandom_range(0, 2))
                    0: stuck1 = W'(1) << $urandom_range(0, W - 1);
                    1: stuck0 = W'(1) << $urandom_range(0, W - 1);
                    default: ;
                endcase
            end
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
